// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the input-conditioning stages.
//   state_t            debouncer FSM state encoding
//   DEF_STABLE_CYCLES  default number of stable samples needed to change level
package debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW,
      S_TO_HIGH,
      S_HIGH,
      S_TO_LOW
   } state_t;

   localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
//   clk  system clock
//   rst  synchronous active-high reset, clears both flops
//   d    asynchronous input
//   q    synchronized output, two clocks behind d
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         q  <= 1'b0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: turns a raw bouncy input into a clean clock-aligned level,
// with one-cycle rise/fall strobes and a wrapping count of qualified presses.
//   clk          system clock
//   rst          synchronous active-high reset
//   din          raw asynchronous input
//   level_out    debounced level
//   rise_pulse   one-cycle strobe on level_out 0->1
//   fall_pulse   one-cycle strobe on level_out 1->0
//   press_count  qualified rising edges since reset, wraps silently
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int PRESS_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   output logic               level_out,
   output logic               rise_pulse,
   output logic               fall_pulse,
   output logic [PRESS_W-1:0] press_count
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s2)
   );

   // cnt holds how many consecutive samples of the new value have been seen
   // while qualifying; the sample that moves us into S_TO_* counts as 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_LOW;
         cnt         <= '0;
         level_out   <= 1'b0;
         rise_pulse  <= 1'b0;
         fall_pulse  <= 1'b0;
         press_count <= '0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            S_LOW: begin
               if (s2) begin
                  state <= S_TO_HIGH;
                  cnt   <= CNT_ONE;
               end else begin
                  cnt <= '0;
               end
            end
            S_TO_HIGH: begin
               if (!s2) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state       <= S_HIGH;
                  cnt         <= '0;
                  level_out   <= 1'b1;
                  rise_pulse  <= 1'b1;
                  press_count <= press_count + PRESS_W'(1);
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!s2) begin
                  state <= S_TO_LOW;
                  cnt   <= CNT_ONE;
               end
            end
            S_TO_LOW: begin
               if (s2) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= S_LOW;
                  cnt        <= '0;
                  level_out  <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= S_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
